// File: rtl/flow_target_xfer.sv
// flow_target_xfer
//
// Target-side transfer engine between the bus FSM byte stream and the TTI queues.
//   - Private writes: bytes are packed little-endian into RxDataWidth words for the
//     RX data queue. On stop, any partial word is flushed, then a byte-count
//     descriptor is posted.
//   - Private reads: TxDataWidth words from the TX queue are sent LSB byte first.
//   - CCC: bytes are accepted and counted, but never queued.
//
// Ports
//   clk_i, rst_i                      clock, synchronous active-high reset
//   enable_i                          engine enable; low returns to Idle and clears everything
//   transfer_start_i/stop_i/type_i    transfer framing from the bus FSM
//   rx_byte_*                         bus RX byte handshake (bus -> engine)
//   tx_byte_*                         bus TX byte handshake (engine -> bus)
//   rx_queue_w*                       RX data queue write port
//   rx_desc_w*                        RX descriptor queue write port
//   tx_queue_r*                       TX data queue read port
//   err_type_o, err_underrun_o        single-cycle error pulses
//   xfer_cnt_o                        bytes moved in the current or last transfer
module flow_target_xfer #(
    parameter int RxDataWidth = 32,
    parameter int TxDataWidth = 32,
    parameter int CntWidth    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic                   transfer_start_i,
    input  logic                   transfer_stop_i,
    input  logic [1:0]             transfer_type_i,
    input  logic                   rx_byte_valid_i,
    output logic                   rx_byte_ready_o,
    input  logic [7:0]             rx_byte_i,
    output logic                   tx_byte_valid_o,
    input  logic                   tx_byte_ready_i,
    output logic [7:0]             tx_byte_o,
    output logic                   rx_queue_wvalid_o,
    input  logic                   rx_queue_wready_i,
    output logic [RxDataWidth-1:0] rx_queue_wdata_o,
    output logic                   rx_desc_wvalid_o,
    input  logic                   rx_desc_wready_i,
    output logic [CntWidth-1:0]    rx_desc_wdata_o,
    input  logic                   tx_queue_rvalid_i,
    output logic                   tx_queue_rready_o,
    input  logic [TxDataWidth-1:0] tx_queue_rdata_i,
    output logic                   err_type_o,
    output logic                   err_underrun_o,
    output logic [CntWidth-1:0]    xfer_cnt_o
);

    localparam int RxBytes = RxDataWidth / 8;
    localparam int TxBytes = TxDataWidth / 8;
    localparam int IdxW    = (RxBytes > 1) ? $clog2(RxBytes) : 1;
    localparam int TxCntW  = $clog2(TxBytes + 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_WAIT  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DESC  = 3'd4;
    localparam logic [2:0] ST_READ  = 3'd5;
    localparam logic [2:0] ST_CCC   = 3'd6;

    logic [2:0]             state_q;
    logic [CntWidth-1:0]    xfer_cnt_q;
    logic [RxDataWidth-1:0] rx_acc_q;
    logic [RxDataWidth-1:0] rx_acc_next;
    logic [RxDataWidth-1:0] rx_word_q;
    logic [IdxW-1:0]        rx_idx_q;
    logic [IdxW-1:0]        rx_idx_next;
    logic                   rx_wvalid_q;
    logic [TxDataWidth-1:0] tx_buf_q;
    logic [TxCntW-1:0]      tx_cnt_q;
    logic                   err_type_q;
    logic                   err_underrun_q;
    logic                   underrun_seen_q;

    logic rx_stuck;
    logic rx_last_lane;
    logic wr_take;
    logic ccc_take;
    logic txq_take;
    logic tx_take;

    // Byte counter saturates at all-ones rather than wrapping.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        return (&v) ? v : v + CntWidth'(1);
    endfunction

    // A full word that the queue has not taken yet blocks further bytes.
    assign rx_stuck     = rx_wvalid_q & ~rx_queue_wready_i;
    assign rx_last_lane = (rx_idx_q == IdxW'(RxBytes - 1));

    always_comb begin
        rx_byte_ready_o = 1'b0;
        if (state_q == ST_WRITE) begin
            rx_byte_ready_o = ~rx_stuck;
        end else if (state_q == ST_CCC) begin
            rx_byte_ready_o = 1'b1;
        end
    end

    assign wr_take  = (state_q == ST_WRITE) & rx_byte_valid_i & rx_byte_ready_o;
    assign ccc_take = (state_q == ST_CCC) & rx_byte_valid_i;

    // Insert the incoming byte into the lane selected by the running index.
    always_comb begin
        rx_acc_next = rx_acc_q;
        for (int i = 0; i < RxBytes; i++) begin
            if (rx_idx_q == IdxW'(i)) begin
                rx_acc_next[8*i +: 8] = rx_byte_i;
            end
        end
        rx_idx_next = rx_last_lane ? '0 : rx_idx_q + IdxW'(1);
    end

    assign tx_queue_rready_o = (state_q == ST_READ) && (tx_cnt_q == '0);
    assign tx_byte_valid_o   = (state_q == ST_READ) && (tx_cnt_q != '0);
    assign tx_byte_o         = tx_buf_q[7:0];
    assign txq_take          = tx_queue_rready_o & tx_queue_rvalid_i;
    assign tx_take           = tx_byte_valid_o & tx_byte_ready_i;

    assign rx_queue_wvalid_o = rx_wvalid_q;
    assign rx_queue_wdata_o  = rx_word_q;
    assign rx_desc_wvalid_o  = (state_q == ST_DESC);
    assign rx_desc_wdata_o   = (state_q == ST_DESC) ? xfer_cnt_q : '0;
    assign err_type_o        = err_type_q;
    assign err_underrun_o    = err_underrun_q;
    assign xfer_cnt_o        = xfer_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || !enable_i) begin
            state_q         <= ST_IDLE;
            xfer_cnt_q      <= '0;
            rx_acc_q        <= '0;
            rx_word_q       <= '0;
            rx_idx_q        <= '0;
            rx_wvalid_q     <= 1'b0;
            tx_buf_q        <= '0;
            tx_cnt_q        <= '0;
            err_type_q      <= 1'b0;
            err_underrun_q  <= 1'b0;
            underrun_seen_q <= 1'b0;
        end else begin
            err_type_q     <= 1'b0;
            err_underrun_q <= 1'b0;

            // Queue handshake retires the held word; a new load below overrides this.
            if (rx_wvalid_q && rx_queue_wready_i) begin
                rx_wvalid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (transfer_start_i) begin
                        case (transfer_type_i)
                            2'b00: begin
                                state_q    <= ST_WRITE;
                                xfer_cnt_q <= '0;
                            end
                            2'b01: begin
                                state_q         <= ST_READ;
                                xfer_cnt_q      <= '0;
                                underrun_seen_q <= 1'b0;
                            end
                            2'b10: begin
                                state_q    <= ST_CCC;
                                xfer_cnt_q <= '0;
                            end
                            default: begin
                                err_type_q <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_WRITE: begin
                    if (wr_take) begin
                        xfer_cnt_q <= sat_inc(xfer_cnt_q);
                        rx_idx_q   <= rx_idx_next;
                        if (rx_last_lane) begin
                            rx_word_q   <= rx_acc_next;
                            rx_wvalid_q <= 1'b1;
                            rx_acc_q    <= '0;
                        end else begin
                            rx_acc_q <= rx_acc_next;
                        end
                    end
                    if (transfer_stop_i) begin
                        if (wr_take && rx_last_lane) begin
                            // Word just completed; descriptor waits for it to drain.
                            state_q <= ST_FLUSH;
                        end else if (wr_take || (rx_idx_q != '0)) begin
                            // Partial word: post it now unless a full word still blocks the port.
                            // A byte can only be taken when the port is not blocked.
                            if (!rx_stuck) begin
                                rx_word_q   <= wr_take ? rx_acc_next : rx_acc_q;
                                rx_wvalid_q <= 1'b1;
                                rx_acc_q    <= '0;
                                rx_idx_q    <= '0;
                            end
                            state_q <= ST_FLUSH;
                        end else if (rx_stuck) begin
                            state_q <= ST_FLUSH;
                        end else begin
                            state_q <= ST_DESC;
                        end
                    end
                end

                ST_FLUSH: begin
                    if (rx_wvalid_q) begin
                        if (rx_queue_wready_i) begin
                            if (rx_idx_q != '0) begin
                                rx_word_q   <= rx_acc_q;
                                rx_wvalid_q <= 1'b1;
                                rx_acc_q    <= '0;
                                rx_idx_q    <= '0;
                            end else begin
                                state_q <= ST_DESC;
                            end
                        end
                    end else if (rx_idx_q != '0) begin
                        rx_word_q   <= rx_acc_q;
                        rx_wvalid_q <= 1'b1;
                        rx_acc_q    <= '0;
                        rx_idx_q    <= '0;
                    end else begin
                        state_q <= ST_DESC;
                    end
                end

                ST_DESC: begin
                    if (rx_desc_wready_i) begin
                        state_q <= ST_WAIT;
                    end
                end

                ST_READ: begin
                    if (txq_take) begin
                        tx_buf_q <= tx_queue_rdata_i;
                        tx_cnt_q <= TxCntW'(TxBytes);
                    end else if (tx_take) begin
                        tx_buf_q   <= tx_buf_q >> 8;
                        tx_cnt_q   <= tx_cnt_q - TxCntW'(1);
                        xfer_cnt_q <= sat_inc(xfer_cnt_q);
                    end else if ((tx_cnt_q == '0) && tx_byte_ready_i && !underrun_seen_q) begin
                        // Reported once per read transfer.
                        err_underrun_q  <= 1'b1;
                        underrun_seen_q <= 1'b1;
                    end
                    if (transfer_stop_i) begin
                        // Unsent bytes are dropped, not returned to the queue.
                        state_q  <= ST_WAIT;
                        tx_buf_q <= '0;
                        tx_cnt_q <= '0;
                    end
                end

                ST_CCC: begin
                    if (ccc_take) begin
                        xfer_cnt_q <= sat_inc(xfer_cnt_q);
                    end
                    if (transfer_stop_i) begin
                        state_q <= ST_WAIT;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flow_target_xfer.sv
// Directed testbench for flow_target_xfer with a scoreboard of expected RX words,
// RX descriptors and TX bytes, compared by a monitor at each DUT handshake.
module tb_flow_target_xfer;

    localparam int RXW = 32;
    localparam int TXW = 32;
    localparam int CW  = 16;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           enable_i;
    logic           transfer_start_i;
    logic           transfer_stop_i;
    logic [1:0]     transfer_type_i;
    logic           rx_byte_valid_i;
    logic           rx_byte_ready_o;
    logic [7:0]     rx_byte_i;
    logic           tx_byte_valid_o;
    logic           tx_byte_ready_i;
    logic [7:0]     tx_byte_o;
    logic           rx_queue_wvalid_o;
    logic           rx_queue_wready_i;
    logic [RXW-1:0] rx_queue_wdata_o;
    logic           rx_desc_wvalid_o;
    logic           rx_desc_wready_i;
    logic [CW-1:0]  rx_desc_wdata_o;
    logic           tx_queue_rvalid_i;
    logic           tx_queue_rready_o;
    logic [TXW-1:0] tx_queue_rdata_i;
    logic           err_type_o;
    logic           err_underrun_o;
    logic [CW-1:0]  xfer_cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [31:0] rx_exp_q[$];
    logic [15:0] desc_exp_q[$];
    logic [7:0]  tx_exp_q[$];

    always #5 clk = ~clk;

    flow_target_xfer #(
        .RxDataWidth(RXW),
        .TxDataWidth(TXW),
        .CntWidth(CW)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .enable_i(enable_i),
        .transfer_start_i(transfer_start_i),
        .transfer_stop_i(transfer_stop_i),
        .transfer_type_i(transfer_type_i),
        .rx_byte_valid_i(rx_byte_valid_i),
        .rx_byte_ready_o(rx_byte_ready_o),
        .rx_byte_i(rx_byte_i),
        .tx_byte_valid_o(tx_byte_valid_o),
        .tx_byte_ready_i(tx_byte_ready_i),
        .tx_byte_o(tx_byte_o),
        .rx_queue_wvalid_o(rx_queue_wvalid_o),
        .rx_queue_wready_i(rx_queue_wready_i),
        .rx_queue_wdata_o(rx_queue_wdata_o),
        .rx_desc_wvalid_o(rx_desc_wvalid_o),
        .rx_desc_wready_i(rx_desc_wready_i),
        .rx_desc_wdata_o(rx_desc_wdata_o),
        .tx_queue_rvalid_i(tx_queue_rvalid_i),
        .tx_queue_rready_o(tx_queue_rready_o),
        .tx_queue_rdata_i(tx_queue_rdata_i),
        .err_type_o(err_type_o),
        .err_underrun_o(err_underrun_o),
        .xfer_cnt_o(xfer_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next active edge; inputs change here, outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic with_stop);
        rx_byte_valid_i = 1'b1;
        rx_byte_i       = b;
        for (int k = 0; k < 50; k++) begin
            if (rx_byte_ready_o) break;
            step();
        end
        chk("send_ready", {31'd0, rx_byte_ready_o}, 32'd1);
        transfer_stop_i = with_stop;
        step();
        rx_byte_valid_i = 1'b0;
        transfer_stop_i = 1'b0;
    endtask

    task automatic start_xfer(input logic [1:0] t);
        transfer_start_i = 1'b1;
        transfer_type_i  = t;
        step();
        transfer_start_i = 1'b0;
        transfer_type_i  = 2'b00;
    endtask

    // Scoreboard monitor: samples handshakes mid-cycle, before the edge that completes them.
    always @(negedge clk) begin
        if (rx_queue_wvalid_o && rx_queue_wready_i) begin
            chk("rx_word_expected", {31'd0, (rx_exp_q.size() != 0)}, 32'd1);
            if (rx_exp_q.size() != 0) chk("rx_word", rx_queue_wdata_o, rx_exp_q.pop_front());
        end
        if (rx_desc_wvalid_o && rx_desc_wready_i) begin
            chk("desc_expected", {31'd0, (desc_exp_q.size() != 0)}, 32'd1);
            if (desc_exp_q.size() != 0) chk("desc", {16'd0, rx_desc_wdata_o}, {16'd0, desc_exp_q.pop_front()});
        end
        if (tx_byte_valid_o && tx_byte_ready_i) begin
            chk("tx_expected", {31'd0, (tx_exp_q.size() != 0)}, 32'd1);
            if (tx_exp_q.size() != 0) chk("tx_byte", {24'd0, tx_byte_o}, {24'd0, tx_exp_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        rst_i             = 1'b1;
        enable_i          = 1'b0;
        transfer_start_i  = 1'b0;
        transfer_stop_i   = 1'b0;
        transfer_type_i   = 2'b00;
        rx_byte_valid_i   = 1'b0;
        rx_byte_i         = 8'h00;
        tx_byte_ready_i   = 1'b0;
        rx_queue_wready_i = 1'b1;
        rx_desc_wready_i  = 1'b1;
        tx_queue_rvalid_i = 1'b0;
        tx_queue_rdata_i  = '0;

        step(); step(); step();
        chk("reset_ctrl", {25'd0, rx_byte_ready_o, rx_queue_wvalid_o, rx_desc_wvalid_o,
                           tx_byte_valid_o, tx_queue_rready_o, err_type_o, err_underrun_o}, 32'd0);
        chk("reset_cnt", {16'd0, xfer_cnt_o}, 32'd0);
        chk("reset_wdata", rx_queue_wdata_o, 32'd0);

        rst_i    = 1'b0;
        enable_i = 1'b1;
        step(); step();

        // Illegal type: error pulse, engine stays in Wait.
        start_xfer(2'b11);
        chk("err_type_pulse", {31'd0, err_type_o}, 32'd1);
        chk("wait_not_ready", {31'd0, rx_byte_ready_o}, 32'd0);
        step();
        chk("err_type_one_cycle", {31'd0, err_type_o}, 32'd0);

        // Write of 5 bytes: one full word, one partial, then descriptor 5.
        rx_exp_q.push_back(32'h44332211);
        rx_exp_q.push_back(32'h00000055);
        desc_exp_q.push_back(16'd5);
        start_xfer(2'b00);
        chk("wr_ready", {31'd0, rx_byte_ready_o}, 32'd1);
        chk("wr_cnt_clear", {16'd0, xfer_cnt_o}, 32'd0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        chk("wr_word_valid_next", {31'd0, rx_queue_wvalid_o}, 32'd1);
        send_byte(8'h55, 1'b1);
        chk("wr_partial_valid", {31'd0, rx_queue_wvalid_o}, 32'd1);
        chk("wr_cnt5", {16'd0, xfer_cnt_o}, 32'd5);
        step();
        chk("wr_desc_valid", {31'd0, rx_desc_wvalid_o}, 32'd1);
        chk("wr_desc_data", {16'd0, rx_desc_wdata_o}, 32'd5);
        step();
        chk("wr_desc_done", {31'd0, rx_desc_wvalid_o}, 32'd0);
        chk("wr_cnt_hold", {16'd0, xfer_cnt_o}, 32'd5);

        // Write with the RX queue stalled after the first word; stop arrives during the stall.
        rx_exp_q.push_back(32'h04030201);
        desc_exp_q.push_back(16'd4);
        start_xfer(2'b00);
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h03, 1'b0);
        rx_queue_wready_i = 1'b0;
        send_byte(8'h04, 1'b0);
        for (int k = 0; k < 10; k++) begin
            chk("stall_ready", {31'd0, rx_byte_ready_o}, 32'd0);
            chk("stall_wvalid", {31'd0, rx_queue_wvalid_o}, 32'd1);
            chk("stall_wdata", rx_queue_wdata_o, 32'h04030201);
            rx_byte_valid_i = (k < 2);
            rx_byte_i       = 8'hEE;
            transfer_stop_i = (k == 3);
            step();
        end
        rx_byte_valid_i = 1'b0;
        transfer_stop_i = 1'b0;
        chk("stall_cnt", {16'd0, xfer_cnt_o}, 32'd4);
        chk("stall_no_desc", {31'd0, rx_desc_wvalid_o}, 32'd0);
        rx_queue_wready_i = 1'b1;
        step();
        chk("stall_desc_valid", {31'd0, rx_desc_wvalid_o}, 32'd1);
        chk("stall_desc_data", {16'd0, rx_desc_wdata_o}, 32'd4);
        step();

        // Read: two words, stop on the sixth byte handshake.
        tx_exp_q.push_back(8'hD4);
        tx_exp_q.push_back(8'hC3);
        tx_exp_q.push_back(8'hB2);
        tx_exp_q.push_back(8'hA1);
        tx_exp_q.push_back(8'h04);
        tx_exp_q.push_back(8'h03);
        tx_queue_rvalid_i = 1'b1;
        tx_queue_rdata_i  = 32'hA1B2C3D4;
        tx_byte_ready_i   = 1'b1;
        start_xfer(2'b01);
        chk("rd_rready", {31'd0, tx_queue_rready_o}, 32'd1);
        step();
        tx_queue_rdata_i = 32'h01020304;
        chk("rd_byte0_valid", {31'd0, tx_byte_valid_o}, 32'd1);
        chk("rd_byte0", {24'd0, tx_byte_o}, 32'h000000D4);
        hs = 0;
        for (int k = 0; k < 40; k++) begin
            if (tx_byte_valid_o && tx_byte_ready_i) begin
                hs++;
                if (hs == 6) begin
                    transfer_stop_i   = 1'b1;
                    tx_queue_rvalid_i = 1'b0;
                end
            end
            step();
            if (hs == 6) break;
            if (hs == 4 && !tx_byte_valid_o) begin
                chk("rd_bubble_rready", {31'd0, tx_queue_rready_o}, 32'd1);
            end
        end
        transfer_stop_i = 1'b0;
        chk("rd_hs_count", hs, 32'd6);
        chk("rd_after_stop_valid", {31'd0, tx_byte_valid_o}, 32'd0);
        chk("rd_after_stop_rready", {31'd0, tx_queue_rready_o}, 32'd0);
        chk("rd_cnt6", {16'd0, xfer_cnt_o}, 32'd6);
        chk("rd_no_underrun", {31'd0, err_underrun_o}, 32'd0);

        // Read with an empty TX queue: one underrun pulse only.
        start_xfer(2'b01);
        chk("ur_before", {31'd0, err_underrun_o}, 32'd0);
        step();
        chk("ur_pulse", {31'd0, err_underrun_o}, 32'd1);
        chk("ur_no_byte", {31'd0, tx_byte_valid_o}, 32'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("ur_single", {31'd0, err_underrun_o}, 32'd0);
        end
        transfer_stop_i = 1'b1;
        step();
        transfer_stop_i = 1'b0;
        tx_byte_ready_i = 1'b0;

        // CCC: three bytes counted, nothing queued.
        start_xfer(2'b10);
        send_byte(8'hC1, 1'b0);
        send_byte(8'hC2, 1'b0);
        send_byte(8'hC3, 1'b0);
        transfer_stop_i = 1'b1;
        step();
        transfer_stop_i = 1'b0;
        chk("ccc_cnt3", {16'd0, xfer_cnt_o}, 32'd3);
        chk("ccc_no_queue", {30'd0, rx_queue_wvalid_o, rx_desc_wvalid_o}, 32'd0);
        chk("ccc_back_wait", {31'd0, rx_byte_ready_o}, 32'd0);

        // Enable dropped mid-write after two bytes.
        start_xfer(2'b00);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        chk("en_cnt2", {16'd0, xfer_cnt_o}, 32'd2);
        enable_i = 1'b0;
        step();
        chk("en_off_ctrl", {25'd0, rx_byte_ready_o, rx_queue_wvalid_o, rx_desc_wvalid_o,
                            tx_byte_valid_o, tx_queue_rready_o, err_type_o, err_underrun_o}, 32'd0);
        chk("en_off_cnt", {16'd0, xfer_cnt_o}, 32'd0);
        step();
        step();
        chk("en_off_no_desc", {31'd0, rx_desc_wvalid_o}, 32'd0);
        enable_i = 1'b1;
        step(); step();

        // Reset in the middle of a read.
        tx_queue_rvalid_i = 1'b1;
        tx_queue_rdata_i  = 32'h55667788;
        start_xfer(2'b01);
        step();
        tx_queue_rvalid_i = 1'b0;
        chk("rst_rd_valid", {31'd0, tx_byte_valid_o}, 32'd1);
        chk("rst_rd_byte", {24'd0, tx_byte_o}, 32'h00000088);
        rst_i = 1'b1;
        step();
        chk("rst_ctrl", {25'd0, rx_byte_ready_o, rx_queue_wvalid_o, rx_desc_wvalid_o,
                         tx_byte_valid_o, tx_queue_rready_o, err_type_o, err_underrun_o}, 32'd0);
        chk("rst_byte", {24'd0, tx_byte_o}, 32'd0);
        chk("rst_cnt", {16'd0, xfer_cnt_o}, 32'd0);
        rst_i = 1'b0;
        step();

        chk("sb_rx_empty", rx_exp_q.size(), 32'd0);
        chk("sb_desc_empty", desc_exp_q.size(), 32'd0);
        chk("sb_tx_empty", tx_exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
